// File: rtl/riv_async_fifo_wr_ctrl_if.sv
// rtl/riv_async_fifo_wr_ctrl_if.sv - write-side bundle of the riv async FIFO: user, memory and cdc signals
interface riv_async_fifo_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  wr_en;
   logic                  full;
   logic                  almost_full;
   logic [ADDR_WIDTH-1:0] wr_level;
   logic                  overflow;
   logic                  mem_we;
   logic [ADDR_WIDTH-2:0] mem_waddr;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  wr_fsm_load;
   logic                  wr_fsm_req_ack;
   logic                  wr_fsm_recv_ack;
   logic [ADDR_WIDTH-1:0] raddr_wr;

   modport slave (
      input  wr_en, wr_fsm_recv_ack, raddr_wr,
      output full, almost_full, wr_level, overflow, mem_we, mem_waddr, waddr,
             wr_fsm_load, wr_fsm_req_ack
   );

   modport master (
      output wr_en, wr_fsm_recv_ack, raddr_wr,
      input  full, almost_full, wr_level, overflow, mem_we, mem_waddr, waddr,
             wr_fsm_load, wr_fsm_req_ack
   );
endinterface

// File: rtl/riv_async_fifo_wr_ctrl.sv
// rtl/riv_async_fifo_wr_ctrl.sv - write pointer, full/level flags and 4-phase pointer handshake
module riv_async_fifo_wr_ctrl #(
   parameter int ADDR_WIDTH   = 10,
   parameter int AFULL_THRESH = 2**(ADDR_WIDTH-1)-2
) (
   input logic                      wclk,
   input logic                      wrst_n,
   riv_async_fifo_wr_ctrl_if.slave  bus
);
   localparam logic [ADDR_WIDTH-1:0] DEPTH = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
   localparam logic [ADDR_WIDTH-1:0] AFULL = ADDR_WIDTH'(AFULL_THRESH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [ADDR_WIDTH-1:0] sent_ptr;
   logic [ADDR_WIDTH-1:0] level;
   logic                  full_w;
   logic                  we;
   logic                  overflow_q;
   logic                  load_q;
   logic                  req_q;

   // raddr_wr lags the reader, so level can only overstate occupancy
   assign level  = waddr_q - bus.raddr_wr;
   assign full_w = (level == DEPTH);
   assign we     = bus.wr_en & ~full_w & wrst_n;

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         waddr_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (we)
            waddr_q <= waddr_q + 1'b1;
         if (bus.wr_en && full_w)
            overflow_q <= 1'b1;
      end
   end

   // snapshot taken in LOAD is the pre-increment waddr, matching what cdc latches
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         state    <= S_IDLE;
         sent_ptr <= '0;
         load_q   <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (waddr_q != sent_ptr) begin
                  state  <= S_LOAD;
                  load_q <= 1'b1;
               end
            end
            S_LOAD: begin
               sent_ptr <= waddr_q;
               load_q   <= 1'b0;
               req_q    <= 1'b1;
               state    <= S_REQ;
            end
            S_REQ: begin
               if (bus.wr_fsm_recv_ack) begin
                  req_q <= 1'b0;
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!bus.wr_fsm_recv_ack)
                  state <= S_IDLE;
            end
            default: begin
               state  <= S_IDLE;
               load_q <= 1'b0;
               req_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.full           = full_w;
   assign bus.almost_full    = (level >= AFULL);
   assign bus.wr_level       = level;
   assign bus.overflow       = overflow_q;
   assign bus.mem_we         = we;
   assign bus.mem_waddr      = waddr_q[ADDR_WIDTH-2:0];
   assign bus.waddr          = waddr_q;
   assign bus.wr_fsm_load    = load_q & wrst_n;
   assign bus.wr_fsm_req_ack = req_q & wrst_n;
endmodule

// File: tb/tb_riv_async_fifo_wr_ctrl.sv
// tb/tb_riv_async_fifo_wr_ctrl.sv - scoreboard bench for riv_async_fifo_wr_ctrl (ADDR_WIDTH=4)
module tb_riv_async_fifo_wr_ctrl;
   localparam int AW = 4;

   logic wclk;
   logic wrst_n;
   logic ack_on;
   int   n_cmp;
   int   n_err;
   int   ack_cnt;

   logic [AW-1:0] exp_load[$];
   logic [AW-2:0] exp_mem[$];

   riv_async_fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   riv_async_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(6)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bus    (bus)
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   function automatic logic pick(input int sel);
      return (sel == 0) ? bus.wr_fsm_req_ack : bus.wr_fsm_recv_ack;
   endfunction

   task automatic wait_for(input int sel, input logic val, input int maxc, input string name);
      int n = 0;
      while (pick(sel) !== val && n < maxc) begin
         tick();
         n++;
      end
      chk(name, 32'(pick(sel)), 32'(val));
   endtask

   // cdc model: recv_ack follows req_ack by 5 cycles in both directions
   initial begin
      bus.wr_fsm_recv_ack = 1'b0;
      ack_cnt = 0;
      forever begin
         @(negedge wclk);
         #2;
         if (!wrst_n || !ack_on) begin
            bus.wr_fsm_recv_ack = 1'b0;
            ack_cnt = 0;
         end else if (bus.wr_fsm_recv_ack != bus.wr_fsm_req_ack) begin
            ack_cnt++;
            if (ack_cnt >= 5) begin
               bus.wr_fsm_recv_ack = bus.wr_fsm_req_ack;
               ack_cnt = 0;
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   // monitor: pops expected loads and memory writes as the DUT presents them
   initial begin
      forever begin
         @(negedge wclk);
         if (!wrst_n) begin
            chk("reset_outputs_low",
                32'({bus.mem_we, bus.wr_fsm_load, bus.wr_fsm_req_ack}), 32'd0);
         end
         if (bus.mem_we) begin
            if (exp_mem.size() == 0)
               chk("mem_we_unexpected", 32'd1, 32'd0);
            else
               chk("mem_waddr", 32'(bus.mem_waddr), 32'(exp_mem.pop_front()));
         end
         if (bus.wr_fsm_load) begin
            if (exp_load.size() == 0)
               chk("load_unexpected", 32'(bus.waddr), 32'hFFFF);
            else
               chk("load_waddr", 32'(bus.waddr), 32'(exp_load.pop_front()));
            chk("load_while_recv_ack", 32'(bus.wr_fsm_recv_ack), 32'd0);
         end
      end
   end

   initial begin
      logic bad;
      int   n;
      n_cmp = 0;
      n_err = 0;
      ack_on = 1'b0;
      bus.wr_en = 1'b0;
      bus.raddr_wr = '0;
      wrst_n = 1'b1;

      // 1. reset with wr_en held high
      @(posedge wclk);
      #1;
      wrst_n = 1'b0;
      bus.wr_en = 1'b1;
      repeat (3) tick();
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_waddr", 32'(bus.waddr), 32'd0);
      chk("rst_load", 32'(bus.wr_fsm_load), 32'd0);
      chk("rst_req", 32'(bus.wr_fsm_req_ack), 32'd0);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_level", 32'(bus.wr_level), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      bus.wr_en = 1'b0;
      wrst_n = 1'b1;
      tick();

      // 2. fill with ack held low: one snapshot of waddr=2 then stuck in REQ
      exp_load.push_back(4'd2);
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1'b1;
         exp_mem.push_back(3'(i));
         tick();
         chk("fill_level", 32'(bus.wr_level), 32'(i + 1));
         chk("fill_afull", 32'(bus.almost_full), 32'((i + 1) >= 6));
         chk("fill_full", 32'(bus.full), 32'((i + 1) == 8));
      end
      tick();
      chk("fill_overflow", 32'(bus.overflow), 32'd1);
      chk("fill_waddr", 32'(bus.waddr), 32'd8);
      bus.wr_en = 1'b0;
      tick();

      // 5. wrap with raddr_wr = 8
      bus.raddr_wr = 4'b1000;
      #1;
      chk("wrap_start_level", 32'(bus.wr_level), 32'd0);
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1'b1;
         exp_mem.push_back(3'(i));
         tick();
      end
      bus.wr_en = 1'b0;
      chk("wrap_waddr", 32'(bus.waddr), 32'd0);
      chk("wrap_full", 32'(bus.full), 32'd1);
      chk("wrap_level", 32'(bus.wr_level), 32'd8);
      bus.raddr_wr = 4'b1001;
      #1;
      chk("wrap_unfull", 32'(bus.full), 32'd0);
      chk("wrap_level7", 32'(bus.wr_level), 32'd7);
      chk("wrap_afull7", 32'(bus.almost_full), 32'd1);

      // 6. reset while stuck in REQ
      chk("pre_rst_req", 32'(bus.wr_fsm_req_ack), 32'd1);
      wrst_n = 1'b0;
      tick();
      chk("rstreq_req", 32'(bus.wr_fsm_req_ack), 32'd0);
      chk("rstreq_waddr", 32'(bus.waddr), 32'd0);
      chk("rstreq_overflow", 32'(bus.overflow), 32'd0);
      wrst_n = 1'b1;
      bus.raddr_wr = '0;
      repeat (4) tick();
      chk("rstreq_idle_req", 32'(bus.wr_fsm_req_ack), 32'd0);
      exp_mem.push_back(3'd0);
      exp_load.push_back(4'd1);
      bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      repeat (3) tick();
      chk("rstreq_load_seen", 32'(exp_load.size()), 32'd0);

      // 3/4. handshake with ack model, 3 writes during REQ
      wrst_n = 1'b0;
      repeat (2) tick();
      wrst_n = 1'b1;
      ack_on = 1'b1;
      tick();
      exp_mem.push_back(3'd0);
      exp_load.push_back(4'd1);
      bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      wait_for(0, 1'b1, 20, "hs_req_rise");
      for (int i = 1; i <= 3; i++) begin
         exp_mem.push_back(3'(i));
         bus.wr_en = 1'b1;
         tick();
      end
      bus.wr_en = 1'b0;
      exp_load.push_back(4'd4);
      bad = 1'b0;
      n = 0;
      while (!bus.wr_fsm_recv_ack && n < 20) begin
         if (!bus.wr_fsm_req_ack)
            bad = 1'b1;
         tick();
         n++;
      end
      chk("hs_req_held", 32'({bad, bus.wr_fsm_recv_ack}), 32'b01);
      wait_for(1, 1'b0, 30, "hs_ack_fall");
      wait_for(0, 1'b1, 20, "hs_req2_rise");
      wait_for(1, 1'b1, 30, "hs_ack2_rise");
      wait_for(1, 1'b0, 30, "hs_ack2_fall");
      repeat (8) tick();
      chk("hs_idle_req", 32'(bus.wr_fsm_req_ack), 32'd0);
      chk("hs_waddr", 32'(bus.waddr), 32'd4);
      chk("load_queue_empty", 32'(exp_load.size()), 32'd0);
      chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
